// File: rtl/tipi_link_pkg.sv
// Shared types and constants for the TIPI register-link host master.
package tipi_link_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_LE_HI,
    S_LE_LO,
    S_CK_HI,
    S_CK_LO,
    S_PAR_HI,
    S_PAR_LO,
    S_DONE
  } state_e;

  // r_rt / r_cd line encodings as seen by the CPLD
  localparam logic RT_TI   = 1'b1;
  localparam logic RT_RPI  = 1'b0;
  localparam logic CD_DATA = 1'b1;
  localparam logic CD_CTRL = 1'b0;

  localparam int unsigned DIV_DEFAULT = 2;

endpackage

// File: rtl/tipi_sync2.sv
// Two-flop synchronizer with synchronous reset for the asynchronous r_din line.
module tipi_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tipi_link_master.sv
// Host-side serial master for the TIPI register link: one byte read (TD/TC)
// or written (RD/RC) per command, all link lines driven from registers.
module tipi_link_master
  import tipi_link_pkg::*;
#(
  parameter int unsigned DIV          = DIV_DEFAULT,
  parameter bit          PARITY_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_ctrl,
  input  logic [0:7] cmd_data,
  output logic       rsp_valid,
  output logic [0:7] rsp_data,
  output logic       rsp_parity_err,
  output logic       busy,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_rt,
  output logic       r_cd,
  output logic       r_dout,
  input  logic       r_din
);

  localparam logic [7:0] TMR_LOAD = 8'(DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic [2:0] bit_q, bit_d;
  logic       wr_q, wr_d;
  logic [0:7] tx_q, tx_d;
  logic [0:7] rsp_data_q, rsp_data_d;
  logic       perr_q, perr_d;
  logic       rt_q, rt_d;
  logic       cd_q, cd_d;
  logic       dout_q, dout_d;
  logic       r_clk_q, r_le_q, rsp_valid_q, busy_q, ready_q;
  logic       din_s;
  logic [2:0] bit_nxt;

  tipi_sync2 u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (r_din),
    .q_o   (din_s)
  );

  assign bit_nxt = bit_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_d      = bit_q;
    wr_d       = wr_q;
    tx_d       = tx_q;
    rsp_data_d = rsp_data_q;
    perr_d     = perr_q;
    rt_d       = rt_q;
    cd_d       = cd_q;
    dout_d     = dout_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d    = S_SETUP;
          tmr_d      = TMR_LOAD;
          bit_d      = 3'd0;
          wr_d       = cmd_write;
          tx_d       = cmd_data;
          rsp_data_d = '0;
          perr_d     = 1'b0;
          rt_d       = cmd_write ? RT_RPI : RT_TI;
          cd_d       = cmd_ctrl ? CD_CTRL : CD_DATA;
          dout_d     = cmd_write & cmd_data[0];
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 8'd1;
        end else begin
          tmr_d = TMR_LOAD;
          case (state_q)
            S_SETUP: state_d = wr_q ? S_CK_HI : S_LE_HI;
            S_LE_HI: state_d = S_LE_LO;
            S_LE_LO: begin
              if (!wr_q)             state_d = S_CK_HI;
              else if (PARITY_CHECK) state_d = S_PAR_HI;
              else                   state_d = S_DONE;
            end
            S_CK_HI: begin
              state_d = S_CK_LO;
              // next write bit only appears once r_clk is low again
              if (wr_q && bit_q != 3'd7) dout_d = tx_q[bit_nxt];
            end
            S_CK_LO: begin
              if (!wr_q) rsp_data_d[bit_q] = din_s;
              if (bit_q == 3'd7) begin
                state_d = wr_q ? S_LE_HI : S_DONE;
              end else begin
                bit_d   = bit_nxt;
                state_d = S_CK_HI;
              end
            end
            S_PAR_HI: state_d = S_PAR_LO;
            S_PAR_LO: begin
              perr_d  = din_s != (^tx_q);
              state_d = S_DONE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      bit_q       <= '0;
      wr_q        <= 1'b0;
      tx_q        <= '0;
      rsp_data_q  <= '0;
      perr_q      <= 1'b0;
      rt_q        <= 1'b0;
      cd_q        <= 1'b0;
      dout_q      <= 1'b0;
      r_clk_q     <= 1'b0;
      r_le_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      bit_q       <= bit_d;
      wr_q        <= wr_d;
      tx_q        <= tx_d;
      rsp_data_q  <= rsp_data_d;
      perr_q      <= perr_d;
      rt_q        <= rt_d;
      cd_q        <= cd_d;
      dout_q      <= dout_d;
      // strobes are registered decodes of the next state so they never glitch
      r_clk_q     <= (state_d == S_CK_HI) || (state_d == S_PAR_HI);
      r_le_q      <= (state_d == S_LE_HI);
      rsp_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
      ready_q     <= (state_d == S_IDLE);
    end
  end

  assign cmd_ready      = ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_parity_err = perr_q;
  assign busy           = busy_q;
  assign r_clk          = r_clk_q;
  assign r_le           = r_le_q;
  assign r_rt           = rt_q;
  assign r_cd           = cd_q;
  assign r_dout         = dout_q;

endmodule
